// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one registered adder ALU among NB_REQ requesters, returning sum + owner ID.
// Latency: grant edge E0, result captured at E0+ALU_LAT+1; one op in flight, ALU_LAT+3 cycles per op.
// Backpressure: response held stable until rsp_ready_i; no new grant issued until the response is taken.
module alu_share_ctrl #(
    parameter int nb_bits = 32,
    parameter int NB_REQ  = 4,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                      clock_i,
    input  logic                      rst_n,
    input  logic [NB_REQ-1:0]         req_valid_i,
    input  logic [NB_REQ*nb_bits-1:0] req_a_i,
    input  logic [NB_REQ*nb_bits-1:0] req_b_i,
    output logic [NB_REQ-1:0]         req_ready_o,
    output logic [nb_bits-1:0]        alu_a_o,
    output logic [nb_bits-1:0]        alu_b_o,
    input  logic [nb_bits:0]          alu_sum_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [nb_bits:0]          rsp_sum_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ID_W-1:0]    last_grant;
    logic               found;
    logic [ID_W-1:0]    win_idx;
    logic [nb_bits-1:0] win_a;
    logic [nb_bits-1:0] win_b;
    logic [NB_REQ-1:0]  grant;
    logic               req_hs;
    int                 cand_d;
    int                 best_d;

    // Round-robin pick: valid requester closest above last_grant (with wrap) wins; grant masked outside IDLE and in reset
    always_comb begin
        found  = 1'b0;
        win_idx = '0;
        win_a  = '0;
        win_b  = '0;
        best_d = NB_REQ;
        cand_d = 0;
        grant  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand_d = (k + NB_REQ - 1 - int'(last_grant)) % NB_REQ;
            if (req_valid_i[k] && (cand_d < best_d)) begin
                best_d  = cand_d;
                found   = 1'b1;
                win_idx = ID_W'(k);
                win_a   = req_a_i[k*nb_bits +: nb_bits];
                win_b   = req_b_i[k*nb_bits +: nb_bits];
            end
        end
        for (int k = 0; k < NB_REQ; k++) begin
            grant[k] = found && (win_idx == ID_W'(k));
        end
        req_ready_o = (state == IDLE && rst_n) ? grant : '0;
        req_hs      = (state == IDLE) && rst_n && found;
    end

    // Next-state logic: one operation at a time, IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_hs) next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock_i) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: latch winner operands, count ALU latency, capture and hold the response
    always_ff @(posedge clock_i) begin
        if (!rst_n) begin
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_sum_o   <= '0;
            wait_cnt    <= '0;
            last_grant  <= ID_W'(NB_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        alu_a_o    <= win_a;
                        alu_b_o    <= win_b;
                        rsp_id_o   <= win_idx;
                        last_grant <= win_idx;
                        wait_cnt   <= CNT_W'(ALU_LAT);
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        rsp_sum_o   <= alu_sum_i;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a registered-adder ALU model and a response scoreboard.
// Grants and responses are observed on the falling edge; expected values come from bench operands.
// Every wait is bounded so the run always reaches its summary line.
module tb_alu_share_ctrl;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [32:0]  alu_sum;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [32:0]  rsp_sum;
    logic         busy;

    logic [31:0]  op_a [4];
    logic [31:0]  op_b [4];

    int           exp_grant_q [$];
    logic [34:0]  rsp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gcount = 0;
    int rcount = 0;
    int gcyc_last = 0;
    int rcyc_last = 0;
    int prev_gcyc = -1;
    bit auto_drop = 0;
    bit lat_chk = 0;
    bit spacing_chk = 0;
    logic [3:0] drop_mask = '0;

    alu_share_ctrl #(
        .nb_bits(32), .NB_REQ(4), .ALU_LAT(1), .ID_W(2)
    ) dut (
        .clock_i(clk), .rst_n(rst_n), .req_valid_i(req_valid),
        .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sum_i(alu_sum),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: one register stage
    always_ff @(posedge clk) alu_sum <= {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < 4; k++) begin
            req_a[k*32 +: 32] = op_a[k];
            req_b[k*32 +: 32] = op_b[k];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [34:0] e;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    chk("ready_onehot", {63'b0, $onehot(req_ready)}, 64'd1);
                    chk("grant_expected", {63'b0, exp_grant_q.size() > 0}, 64'd1);
                    if (exp_grant_q.size() > 0) chk("grant_id", k, exp_grant_q.pop_front());
                    if (spacing_chk && prev_gcyc >= 0) chk("grant_spacing", cyc - prev_gcyc, 4);
                    prev_gcyc = cyc;
                    gcyc_last = cyc;
                    gcount++;
                    rsp_q.push_back({k[1:0], {1'b0, op_a[k]} + {1'b0, op_b[k]}});
                    if (auto_drop) drop_mask[k] = 1'b1;
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                chk("rsp_expected", {63'b0, rsp_q.size() > 0}, 64'd1);
                if (rsp_q.size() > 0) begin
                    e = rsp_q.pop_front();
                    chk("rsp_id", rsp_id, e[34:33]);
                    chk("rsp_sum", rsp_sum, e[32:0]);
                end
                if (lat_chk) chk("rsp_latency", cyc - gcyc_last, 3);
                rcyc_last = cyc;
                rcount++;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int i = 0; i < budget && gcount < target; i++) tick();
        chk("grant_wait", gcount, target);
    endtask

    task automatic wait_rsps(input int target, input int budget);
        for (int i = 0; i < budget && rcount < target; i++) tick();
        chk("rsp_wait", rcount, target);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;

        // 1: reset with all requesters valid
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        @(posedge clk);
        #1;

        // 2: single requester 0, 5 + 10
        rst_n = 1'b1;
        req_valid = 4'b0000;
        op_a[0] = 32'd5;
        op_b[0] = 32'd10;
        rsp_ready = 1'b1;
        auto_drop = 1;
        lat_chk = 1;
        tick();
        chk("idle_busy", busy, 0);
        exp_grant_q.push_back(0);
        req_valid = 4'b0001;
        wait_grants(1, 10);
        chk("t2_alu_a", alu_a, 32'd5);
        chk("t2_alu_b", alu_b, 32'd10);
        chk("t2_busy", busy, 1);
        wait_rsps(1, 10);
        chk("t2_idle_after", busy, 0);
        chk("t2_sum_const", rsp_sum, 33'd15);

        // 3: carry-out passes through
        op_a[2] = 32'hFFFF_FFFF;
        op_b[2] = 32'h1;
        exp_grant_q.push_back(2);
        req_valid = 4'b0100;
        wait_grants(2, 10);
        wait_rsps(2, 10);
        chk("t3_sum_const", rsp_sum, 33'h1_0000_0000);
        chk("t3_id", rsp_id, 2);

        // 4: all valid continuously, starting from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_a[k] = k;
            op_b[k] = 32'h1234_5678;
        end
        for (int k = 0; k < 5; k++) exp_grant_q.push_back(k % 4);
        auto_drop = 0;
        spacing_chk = 1;
        prev_gcyc = -1;
        req_valid = 4'b1111;
        wait_grants(7, 40);
        req_valid = 4'b0000;
        wait_rsps(7, 10);
        spacing_chk = 0;

        // 5: response backpressure while requester 3 waits
        op_a[1] = 32'h1234_5678;
        op_b[1] = 32'h8765_4321;
        op_a[3] = 32'h0000_0003;
        op_b[3] = 32'h0000_0004;
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(3);
        auto_drop = 1;
        lat_chk = 0;
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        wait_grants(8, 10);
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) tick();
        chk("t5_rsp_valid_up", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_sum", rsp_sum, 33'h0_9999_9999);
            chk("t5_hold_id", rsp_id, 1);
            chk("t5_no_grant", req_ready, 0);
        end
        rsp_ready = 1'b1;
        wait_rsps(8, 5);
        wait_grants(9, 5);
        chk("t5_grant3_delay", gcyc_last - rcyc_last, 1);
        wait_rsps(9, 10);

        // 6: reset during WAIT discards the in-flight op and resets the pointer
        lat_chk = 1;
        op_a[0] = 32'h0000_0100;
        op_b[0] = 32'h0000_0200;
        exp_grant_q.push_back(3);
        req_valid = 4'b1000;
        wait_grants(10, 10);
        chk("t6_in_wait", busy, 1);
        tick();
        rst_n = 1'b0;
        req_valid = 4'b1001;
        chk("t6_pending", rsp_q.size(), 1);
        rsp_q.delete();
        tick();
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_busy", busy, 0);
        rst_n = 1'b1;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(3);
        wait_grants(11, 5);
        chk("t6_first_after_rst", gcyc_last - cyc, -1);
        wait_rsps(10, 10);
        wait_grants(12, 10);
        wait_rsps(11, 10);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_quiet", rsp_valid, 0);
        chk("t6_grants_drained", exp_grant_q.size(), 0);
        chk("t6_rsps_drained", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Controller that shares one registered adder ALU (parameter nb_bits, inputs a_i/b_i, output sum_o of nb_bits+1 bits) among NB_REQ requesters. It round-robin arbitrates operand requests, drives the ALU operand inputs and waits the ALU pipeline latency. It then captures the sum and returns it with the requester ID over a valid/ready response channel. It sits between the requester logic and the single ALU instance; the ALU itself is instantiated outside this block.

Parameters:
- nb_bits, 32, operand width; result width is nb_bits+1.
- NB_REQ, 4, number of requesters; minimum 1.
- ALU_LAT, 1, ALU register stages from operand sampling to valid sum_o; minimum 1.
- ID_W, (NB_REQ>1 ? $clog2(NB_REQ) : 1), width of the requester ID.

Ports:
- clock_i  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NB_REQ  bit k: requester k has an operand pair pending.
- req_a_i  in  NB_REQ*nb_bits  packed operand A; slice k belongs to requester k.
- req_b_i  in  NB_REQ*nb_bits  packed operand B; slice k belongs to requester k.
- req_ready_o  out  NB_REQ  one-hot grant; valid&ready on bit k is the request handshake.
- alu_a_o  out  nb_bits  drives ALU a_i.
- alu_b_o  out  nb_bits  drives ALU b_i.
- alu_sum_i  in  nb_bits+1  from ALU sum_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_id_o  out  ID_W  index of the requester that owns the response.
- rsp_sum_o  out  nb_bits+1  captured sum, including the carry-out bit.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clock_i. Reset rst_n is synchronous and active-low and is sampled on the rising edge of clock_i.
- Reset values: state=IDLE; alu_a_o=0; alu_b_o=0; rsp_valid_o=0; rsp_id_o=0; rsp_sum_o=0; wait counter=0; last_grant=NB_REQ-1, so requester 0 has first priority. Outputs then give req_ready_o=0 and busy_o=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, arbitration:
  - req_ready_o is combinational and one-hot.
  - The winner is the first k with req_valid_i[k]=1, scanning from (last_grant+1) mod NB_REQ upward with wrap-around.
  - req_ready_o is 0 when no request is valid.
- IDLE, handshake at edge E0:
  - alu_a_o and alu_b_o register the winner's operand slices.
  - The winner index is latched for rsp_id_o.
  - last_grant is set to the winner index.
  - Wait counter is loaded with ALU_LAT; state goes to WAIT.
- WAIT:
  - req_ready_o=0.
  - Each edge where counter≠0: counter decrements.
  - Edge where counter=0: rsp_sum_o captures alu_sum_i, rsp_valid_o goes to 1, state goes to RESP.
  - Capture therefore occurs at edge E0+ALU_LAT+1 and returns the ALU result for exactly the latched operands.
- RESP:
  - req_ready_o=0.
  - rsp_valid_o, rsp_id_o and rsp_sum_o stay stable while rsp_ready_i=0.
  - On an edge with rsp_ready_i=1: rsp_valid_o goes to 0 and state goes to IDLE.
  - No grant is issued in the same cycle as the response handshake.
- Throughput: at most one operation in flight. With immediate rsp_ready_i, one operation completes every ALU_LAT+3 cycles.
- alu_a_o and alu_b_o hold their last values outside the grant edge and change only on a request handshake.
- Arithmetic: no manipulation. The nb_bits+1 bit sum, carry included, passes through unchanged; the controller does no overflow checking.
- Request withdrawal: a requester may deassert req_valid_i in IDLE before a handshake. Arbitration is combinational, so no stale grant is possible.
- Reset mid-operation (WAIT or RESP):
  - The controller returns to the reset state on that edge.
  - The in-flight result is discarded; rsp_valid_o never asserts for it.
  - The round-robin pointer is reset.
- NB_REQ=1: req_ready_o[0] = req_valid_i[0] in IDLE, and rsp_id_o=0.

Test Plan (bench models the ALU as a registered adder with ALU_LAT=1, nb_bits=32, NB_REQ=4):
1. Hold rst_n=0 for 2 cycles with all req_valid_i set -> req_ready_o=0, rsp_valid_o=0, alu_a_o=0, busy_o=0.
2. Requester 0 only, a=5, b=10, rsp_ready_i=1 -> handshake at E0; rsp_valid_o=1 with rsp_id_o=0, rsp_sum_o=15 after E0+2; IDLE again after E0+3.
3. Requester 2 only, a=32'hFFFFFFFF, b=1 -> rsp_id_o=2, rsp_sum_o=33'h1_0000_0000.
4. All four requesters continuously valid (requester k: a=k, b=32'h12345678) -> grant order 0,1,2,3,0; responses in that order; sums 32'h12345678+k; grants 4 cycles apart.
5. Requester 1 with a=32'h12345678, b=32'h87654321, rsp_ready_i=0 for 5 cycles while requester 3 is valid -> rsp_sum_o=33'h0_99999999 held stable; req_ready_o=0 throughout; requester 3 granted only after the response handshake plus 1 cycle.
6. rst_n=0 for one cycle during WAIT of a requester 3 op, with requester 0 and requester 3 valid afterwards -> no rsp_valid_o for the aborted op; the next grant goes to requester 0.
